// File: rtl/ec_pkg.sv
// Shared definitions for the digit sign-code error check path.
// Holds the controller state encoding, the sign-code width and the default
// digit/correction sizing reused by the downstream correction unit.
package ec_pkg;

    localparam int unsigned SIGN_W      = 2;
    localparam int unsigned EC_NUM_DIG  = 8;
    localparam int unsigned EC_MAX_CORR = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ec_state_e;

endpackage : ec_pkg

// File: rtl/ec_err_tally.sv
// Error mask / count accumulator with word classification.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   clr             start of a new word: zero mask and count
//   acc_en          acc_bit/acc_idx carry a valid comparator result
//   acc_bit         1 when digit acc_idx mismatched
//   acc_idx         digit index of acc_bit
//   fin             last accumulation cycle; flags load from the final count
//   rel             result consumed; flags return to 0
//   err_mask        per-digit error flags
//   err_cnt         number of set bits in err_mask
//   clean / correctable / fatal   classification, valid between fin and rel
module ec_err_tally
    import ec_pkg::*;
#(
    parameter int unsigned NUM_DIG  = EC_NUM_DIG,
    parameter int unsigned MAX_CORR = EC_MAX_CORR,
    parameter int unsigned IDX_W    = $clog2(NUM_DIG),
    parameter int unsigned CNT_W    = $clog2(NUM_DIG + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               acc_en,
    input  logic               acc_bit,
    input  logic [IDX_W-1:0]   acc_idx,
    input  logic               fin,
    input  logic               rel,
    output logic [NUM_DIG-1:0] err_mask,
    output logic [CNT_W-1:0]   err_cnt,
    output logic               clean,
    output logic               correctable,
    output logic               fatal
);

    // Clamp so the threshold always fits in the count width.
    localparam int unsigned MAX_CORR_EFF = (MAX_CORR > NUM_DIG) ? NUM_DIG : MAX_CORR;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_DIG);
    localparam logic [CNT_W-1:0] CORR_MAX = CNT_W'(MAX_CORR_EFF);

    logic [NUM_DIG-1:0] mask_nxt;
    logic [CNT_W-1:0]   cnt_nxt;

    // Next mask/count; the count saturates at NUM_DIG.
    always_comb begin
        mask_nxt = err_mask;
        cnt_nxt  = err_cnt;
        if (clr) begin
            mask_nxt = '0;
            cnt_nxt  = '0;
        end else if (acc_en) begin
            mask_nxt[acc_idx] = acc_bit;
            if (acc_bit && (err_cnt < CNT_MAX)) begin
                cnt_nxt = err_cnt + CNT_W'(1);
            end
        end
    end

    // Mask/count registers; flags load from the count including the final digit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_mask    <= '0;
            err_cnt     <= '0;
            clean       <= 1'b0;
            correctable <= 1'b0;
            fatal       <= 1'b0;
        end else begin
            err_mask <= mask_nxt;
            err_cnt  <= cnt_nxt;
            if (fin) begin
                clean       <= (cnt_nxt == '0);
                correctable <= (cnt_nxt != '0) && (cnt_nxt <= CORR_MAX);
                fatal       <= (cnt_nxt > CORR_MAX);
            end else if (rel) begin
                clean       <= 1'b0;
                correctable <= 1'b0;
                fatal       <= 1'b0;
            end
        end
    end

endmodule : ec_err_tally

// File: rtl/ec_dig_err_scan_ctrl.sv
// Sequencing controller for the per-digit sign-code error check.
// Latches one operand pair, scans one digit per cycle through a registered
// comparator, and presents the error mask, count and classification.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready only in IDLE)
//   sign_a, sign_b        packed 2-bit sign codes, digit k at [2k+1:2k]
//   dig_en                per-digit check enable
//   out_valid / out_ready result handshake, result held until accepted
//   err_mask, err_cnt     per-digit errors and their count
//   clean, correctable, fatal  word classification (0 when out_valid = 0)
//   busy                  controller not idle
module ec_dig_err_scan_ctrl
    import ec_pkg::*;
#(
    parameter int unsigned NUM_DIG  = EC_NUM_DIG,
    parameter int unsigned MAX_CORR = EC_MAX_CORR,
    parameter int unsigned IDX_W    = $clog2(NUM_DIG),
    parameter int unsigned CNT_W    = $clog2(NUM_DIG + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SIGN_W*NUM_DIG-1:0] sign_a,
    input  logic [SIGN_W*NUM_DIG-1:0] sign_b,
    input  logic [NUM_DIG-1:0]        dig_en,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_DIG-1:0]        err_mask,
    output logic [CNT_W-1:0]          err_cnt,
    output logic                      clean,
    output logic                      correctable,
    output logic                      fatal,
    output logic                      busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIG - 1);

    ec_state_e state;
    ec_state_e state_nxt;

    logic                      in_ready_nxt;
    logic                      out_valid_nxt;
    logic                      busy_nxt;
    logic                      accept_c;
    logic                      release_c;

    logic [SIGN_W*NUM_DIG-1:0] a_q;
    logic [SIGN_W*NUM_DIG-1:0] b_q;
    logic [NUM_DIG-1:0]        en_q;
    logic [IDX_W-1:0]          idx;
    logic [IDX_W-1:0]          idx_d;
    logic                      cmp_ff;
    logic                      pv;
    logic                      dig_err_c;

    // State register and registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
            busy      <= busy_nxt;
        end
    end

    // Next state and next-cycle output values.
    always_comb begin
        state_nxt     = state;
        accept_c      = 1'b0;
        release_c     = 1'b0;
        in_ready_nxt  = 1'b0;
        out_valid_nxt = 1'b0;
        busy_nxt      = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept_c  = 1'b1;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (idx == LAST_IDX) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                state_nxt = DONE;
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    release_c = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        in_ready_nxt  = (state_nxt == IDLE);
        out_valid_nxt = (state_nxt == DONE);
        busy_nxt      = (state_nxt != IDLE);
    end

    // Raw 2-bit compare of the digit currently being issued.
    always_comb begin
        dig_err_c = (a_q[idx*SIGN_W +: SIGN_W] != b_q[idx*SIGN_W +: SIGN_W]) && en_q[idx];
    end

    // Operand latch, digit index and the one-cycle comparator stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            en_q   <= '0;
            idx    <= '0;
            idx_d  <= '0;
            cmp_ff <= 1'b0;
            pv     <= 1'b0;
        end else begin
            if (accept_c) begin
                a_q  <= sign_a;
                b_q  <= sign_b;
                en_q <= dig_en;
                idx  <= '0;
            end else if (state == SCAN) begin
                idx <= idx + IDX_W'(1);
            end
            pv <= (state == SCAN);
            if (state == SCAN) begin
                cmp_ff <= dig_err_c;
                idx_d  <= idx;
            end
        end
    end

    ec_err_tally #(
        .NUM_DIG  (NUM_DIG),
        .MAX_CORR (MAX_CORR),
        .IDX_W    (IDX_W),
        .CNT_W    (CNT_W)
    ) u_tally (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (accept_c),
        .acc_en      (pv),
        .acc_bit     (cmp_ff),
        .acc_idx     (idx_d),
        .fin         (state == DRAIN),
        .rel         (release_c),
        .err_mask    (err_mask),
        .err_cnt     (err_cnt),
        .clean       (clean),
        .correctable (correctable),
        .fatal       (fatal)
    );

endmodule : ec_dig_err_scan_ctrl

// File: tb/tb_ec_dig_err_scan_ctrl.sv
// Self-checking bench for ec_dig_err_scan_ctrl: directed words from the
// test plan plus randomized words checked against a digit-loop reference.
module tb_ec_dig_err_scan_ctrl;

    localparam int unsigned ND = 8;
    localparam int unsigned MC = 2;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2*ND-1:0] sign_a;
    logic [2*ND-1:0] sign_b;
    logic [ND-1:0] dig_en;
    logic          out_valid;
    logic          out_ready;
    logic [ND-1:0] err_mask;
    logic [CW-1:0] err_cnt;
    logic          clean;
    logic          correctable;
    logic          fatal;
    logic          busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ec_dig_err_scan_ctrl #(.NUM_DIG(ND), .MAX_CORR(MC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .sign_a      (sign_a),
        .sign_b      (sign_b),
        .dig_en      (dig_en),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .err_mask    (err_mask),
        .err_cnt     (err_cnt),
        .clean       (clean),
        .correctable (correctable),
        .fatal       (fatal),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference: a digit errs when enabled and its two raw codes differ.
    function automatic logic [ND-1:0] model_mask(input logic [2*ND-1:0] a,
                                                 input logic [2*ND-1:0] b,
                                                 input logic [ND-1:0] en);
        logic [ND-1:0] m;
        m = '0;
        for (int k = 0; k < ND; k++) begin
            if (en[k] && (a[2*k +: 2] != b[2*k +: 2])) m[k] = 1'b1;
        end
        return m;
    endfunction

    // {clean, correctable, fatal} for a given error count.
    function automatic logic [2:0] model_class(input int cnt);
        if (cnt == 0) return 3'b100;
        if (cnt <= int'(MC)) return 3'b010;
        return 3'b001;
    endfunction

    task automatic run_word(input string tag, input logic [2*ND-1:0] a, input logic [2*ND-1:0] b,
                            input logic [ND-1:0] en, input int hold, input bit early);
        logic [ND-1:0] em;
        int            ec;
        logic [2:0]    ef;
        int            lat;
        int            hold_eff;
        em = model_mask(a, b, en);
        ec = $countones(em);
        ef = model_class(ec);
        hold_eff = early ? 0 : hold;

        @(negedge clk);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        sign_a   = a;
        sign_b   = b;
        dig_en   = en;
        @(posedge clk); #1;
        check({tag, ".accept"}, 32'({busy, in_ready, out_valid}), 32'b100);
        // Operands now latched; disturb inputs to show they are ignored.
        in_valid  = 1'b0;
        sign_a    = 16'($urandom);
        sign_b    = 16'($urandom);
        dig_en    = 8'($urandom);
        out_ready = early;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(ND + 1));
        check({tag, ".result"}, 32'({in_ready, err_mask, err_cnt, clean, correctable, fatal}),
              32'({1'b0, em, CW'(ec), ef}));

        for (int h = 0; h < hold_eff; h++) begin
            sign_a   = 16'($urandom);
            sign_b   = 16'($urandom);
            in_valid = h[0];
            @(posedge clk); #1;
            check({tag, ".hold"},
                  32'({out_valid, in_ready, busy, err_mask, err_cnt, clean, correctable, fatal}),
                  32'({1'b1, 1'b0, 1'b1, em, CW'(ec), ef}));
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, ".release"}, 32'({out_valid, in_ready, busy, clean, correctable, fatal}),
              32'b010_000);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [2*ND-1:0] ra;
        logic [2*ND-1:0] rb;
        logic [ND-1:0]   ren;
        int              seen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sign_a    = '0;
        sign_b    = '0;
        dig_en    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.state",
              32'({in_ready, out_valid, busy, err_mask, err_cnt, clean, correctable, fatal}),
              32'({1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 3'b000}));
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a scan discards the word.
        @(negedge clk);
        in_valid = 1'b1;
        sign_a   = 16'h0000;
        sign_b   = 16'hFFFF;
        dig_en   = 8'hFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midreset.status", 32'({busy, out_valid, in_ready, err_mask, err_cnt}),
              32'({1'b0, 1'b0, 1'b1, 8'h00, 4'h0}));
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (out_valid || busy) seen++;
        end
        check("midreset.no_stale", 32'(seen), 32'd0);

        run_word("clean",   16'hA5C3, 16'hA5C3, 8'hFF, 0, 1'b0);
        run_word("corr",    16'h0000, 16'h3004, 8'hFF, 1, 1'b0);
        run_word("fatal",   16'h0000, 16'hFFFF, 8'hFF, 0, 1'b0);
        run_word("masked",  16'h0000, 16'hFFFF, 8'h03, 0, 1'b0);
        run_word("bp",      16'h1234, 16'h1334, 8'hFF, 5, 1'b0);
        run_word("bp_next", 16'hFFFF, 16'h0F0F, 8'hF0, 0, 1'b0);
        run_word("early",   16'h5555, 16'h5556, 8'hFF, 0, 1'b1);

        for (int t = 0; t < 40; t++) begin
            ra = 16'($urandom);
            rb = ra;
            for (int k = 0; k < int'(ND); k++) begin
                if ($urandom_range(0, 2) == 0) rb[2*k +: 2] = rb[2*k +: 2] ^ 2'($urandom_range(1, 3));
            end
            ren = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
            run_word("rand", ra, rb, ren, int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_ec_dig_err_scan_ctrl
